// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RV32I datapath (R-type, load, store, beq; others trap).
// Define RETIRE_COUNT_EN to add the retire_count port and its CNT_W-bit counter.
module multicycle_main_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             instr_done,
  output logic             illegal_instr
`ifdef RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0] retire_count
`endif
);

  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StBeq      = 4'd8,
    StTrap     = 4'd9
  } state_e;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (opcode == OpLoad || opcode == OpStore) state_d = StMemAdr;
        else if (opcode == OpRtype)                state_d = StExecR;
        else if (opcode == OpBeq)                  state_d = StBeq;
        else                                       state_d = StTrap;
      end
      StMemAdr:   state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StExecR:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StTrap:     state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Reset overrides decode so an abandoned instruction fires no enable in the reset cycle.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    PCSource      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    RegWrite      = 1'b0;
    MemtoReg      = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        StDecode:   ALUSrcB = 2'b11;
        StMemAdr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRead: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        StMemWrite: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        StExecR: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        StAluWb: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        StBeq: begin
          ALUSrcA    = 1'b1;
          ALUOp      = 2'b01;
          PCSource   = 1'b1;
          PCWrite    = zero;
          instr_done = 1'b1;
        end
        StTrap: begin
          illegal_instr = 1'b1;
          instr_done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RETIRE_COUNT_EN
  logic [CNT_W-1:0] retire_q;

  // Traps finish an instruction slot but retire nothing.
  always_ff @(posedge clk) begin
    if (reset)                               retire_q <= '0;
    else if (instr_done && state_q != StTrap) retire_q <= retire_q + CNT_W'(1);
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: per-opcode phase-string model plus
// directed latency/reset checks. Retire counter checks are active with RETIRE_COUNT_EN.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic mem_req, mem_we, IorD, IRWrite, PCWrite, PCSource, ALUSrcA;
  logic RegWrite, MemtoReg, instr_done, illegal_instr;
  logic [1:0] ALUSrcB, ALUOp;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef RETIRE_COUNT_EN
  logic [31:0] retire_count;
  logic [1:0]  retire_count2;
  logic mem_req2, mem_we2, IorD2, IRWrite2, PCWrite2, PCSource2, ALUSrcA2;
  logic RegWrite2, MemtoReg2, instr_done2, illegal_instr2;
  logic [1:0] ALUSrcB2, ALUOp2;
`endif

  multicycle_main_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
`ifdef RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

`ifdef RETIRE_COUNT_EN
  multicycle_main_control #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req2), .mem_we(mem_we2), .IorD(IorD2), .IRWrite(IRWrite2),
    .PCWrite(PCWrite2), .PCSource(PCSource2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
    .ALUOp(ALUOp2), .RegWrite(RegWrite2), .MemtoReg(MemtoReg2), .instr_done(instr_done2),
    .illegal_instr(illegal_instr2), .retire_count(retire_count2)
  );
`endif

  // {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp,
  //  RegWrite, MemtoReg, instr_done, illegal_instr}
  logic [14:0] dut_vec;
  assign dut_vec = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB,
                    ALUOp, RegWrite, MemtoReg, instr_done, illegal_instr};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Each instruction class as a string of phases, one letter per (non-stalled) cycle.
  function automatic string prog_for(input logic [6:0] op);
    case (op)
      7'b0110011: return "FDXW";
      7'b0000011: return "FDARM";
      7'b0100011: return "FDAS";
      7'b1100011: return "FDB";
      default:    return "FDT";
    endcase
  endfunction

  function automatic logic [14:0] phase_out(input byte ph, input logic mr, input logic z);
    logic req, we, iord, irw, pcw, pcs, sa, rw, m2r, dn, ill;
    logic [1:0] sb, aop;
    {req, we, iord, irw, pcw, pcs, sa, rw, m2r, dn, ill} = '0;
    sb  = 2'b00;
    aop = 2'b00;
    case (ph)
      "F": begin req = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
      "D": sb = 2'b11;
      "A": begin sa = 1'b1; sb = 2'b10; end
      "R": begin req = 1'b1; iord = 1'b1; end
      "M": begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
      "S": begin req = 1'b1; we = 1'b1; iord = 1'b1; dn = mr; end
      "X": begin sa = 1'b1; aop = 2'b10; end
      "W": begin rw = 1'b1; dn = 1'b1; end
      "B": begin sa = 1'b1; aop = 2'b01; pcs = 1'b1; pcw = z; dn = 1'b1; end
      "T": begin ill = 1'b1; dn = 1'b1; end
      default: ;
    endcase
    return {req, we, iord, irw, pcw, pcs, sa, sb, aop, rw, m2r, dn, ill};
  endfunction

  int          m_idx = 0;
  logic [31:0] m_cnt = '0;

  function automatic byte cur_phase();
    string p;
    p = prog_for(opcode);
    return p[m_idx];
  endfunction

  function automatic logic [14:0] model_out();
    if (reset) return '0;
    return phase_out(cur_phase(), mem_ready, zero);
  endfunction

  // Memory phases stall on !mem_ready; otherwise step through the string and wrap to fetch.
  always @(posedge clk) begin
    byte   ph;
    string p;
    p  = prog_for(opcode);
    ph = cur_phase();
    if (reset) begin
      m_idx <= 0;
      m_cnt <= '0;
    end else begin
      if ((ph == "F" || ph == "R" || ph == "S") && !mem_ready) m_idx <= m_idx;
      else m_idx <= (m_idx + 1 == p.len()) ? 0 : m_idx + 1;
      if (model_out() & 15'h0002) m_cnt <= (ph != "T") ? m_cnt + 1 : m_cnt;
    end
  end

  always @(negedge clk) begin
    chk("outputs", {17'd0, dut_vec}, {17'd0, model_out()});
`ifdef RETIRE_COUNT_EN
    chk("retire_count", retire_count, m_cnt);
    chk("retire_count_w2", {30'd0, retire_count2}, {30'd0, m_cnt[1:0]});
    chk("outputs_w2", {17'd0, mem_req2, mem_we2, IorD2, IRWrite2, PCWrite2, PCSource2,
        ALUSrcA2, ALUSrcB2, ALUOp2, RegWrite2, MemtoReg2, instr_done2, illegal_instr2},
        {17'd0, dut_vec});
`endif
  end

  // Runs one instruction from FETCH; mem_ready is low for cycles [lo_s, lo_s+lo_n).
  task automatic run_instr(input string name, input logic [6:0] op, input logic z,
                           input int lo_s, input int lo_n, input int exp_cycles);
    int c = 0;
    bit done = 1'b0;
    opcode = op;
    zero   = z;
    while (!done && c < 40) begin
      mem_ready = !(c >= lo_s && c < lo_s + lo_n);
      @(negedge clk);
      done = instr_done;
      c++;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    chk({name, "_latency"}, c, exp_cycles);
  endtask

  initial begin
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs_zero", {17'd0, dut_vec}, 32'd0);
      @(posedge clk);
    end
    #1 reset = 1'b0;

    run_instr("rtype", 7'b0110011, 1'b0, 99, 0, 4);
    run_instr("load", 7'b0000011, 1'b0, 99, 0, 5);
    run_instr("store", 7'b0100011, 1'b0, 99, 0, 4);
`ifdef RETIRE_COUNT_EN
    @(negedge clk);
    chk("retire_after_3", retire_count, 32'd3);
    @(posedge clk);
    #1;
`endif
    run_instr("beq_taken", 7'b1100011, 1'b1, 99, 0, 3);
`ifdef RETIRE_COUNT_EN
    @(negedge clk);
    chk("retire_w2_wrap", {30'd0, retire_count2}, 32'd0);
    @(posedge clk);
    #1;
`endif
    run_instr("beq_not_taken", 7'b1100011, 1'b0, 99, 0, 3);
    run_instr("fetch_wait3", 7'b0110011, 1'b0, 0, 3, 7);
    run_instr("illegal", 7'b1111111, 1'b0, 99, 0, 3);
    run_instr("load_read_wait2", 7'b0000011, 1'b0, 3, 2, 7);
    run_instr("store_write_wait1", 7'b0100011, 1'b0, 3, 1, 5);

    // Abandon a load in MEMREAD with mem_ready high.
    opcode    = 7'b0000011;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_in_memread_zero", {17'd0, dut_vec}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr("rtype_after_reset", 7'b0110011, 1'b0, 99, 0, 4);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
